// File: rtl/bip_cpu_gen.sv
// Accumulator CPU: single-cycle immediate/branch instructions, memory
// instructions that stall in WAIT until the RAM signals completion.
module bip_cpu_gen #(
    parameter int N_BUS    = 16,
    parameter int N_OP     = 5,
    parameter int N_BUS_IN = 11
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [N_BUS-1:0]    i_instr,
    input  logic [N_BUS-1:0]    i_Out_Data,
    input  logic                i_mem_ready,
    output logic [N_BUS_IN-1:0] o_PC,
    output logic [N_BUS_IN-1:0] o_Addr,
    output logic [N_BUS-1:0]    o_In_Data,
    output logic                o_WrRam,
    output logic                o_RdRam,
    output logic                o_halt,
    output logic [N_BUS-1:0]    o_acc
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [N_OP-1:0] OP_HLT  = N_OP'(0);
    localparam logic [N_OP-1:0] OP_STO  = N_OP'(1);
    localparam logic [N_OP-1:0] OP_LD   = N_OP'(2);
    localparam logic [N_OP-1:0] OP_LDI  = N_OP'(3);
    localparam logic [N_OP-1:0] OP_ADD  = N_OP'(4);
    localparam logic [N_OP-1:0] OP_ADDI = N_OP'(5);
    localparam logic [N_OP-1:0] OP_SUB  = N_OP'(6);
    localparam logic [N_OP-1:0] OP_SUBI = N_OP'(7);
    localparam logic [N_OP-1:0] OP_AND  = N_OP'(8);
    localparam logic [N_OP-1:0] OP_ANDI = N_OP'(9);
    localparam logic [N_OP-1:0] OP_OR   = N_OP'(10);
    localparam logic [N_OP-1:0] OP_ORI  = N_OP'(11);
    localparam logic [N_OP-1:0] OP_XOR  = N_OP'(12);
    localparam logic [N_OP-1:0] OP_XORI = N_OP'(13);
    localparam logic [N_OP-1:0] OP_JMP  = N_OP'(14);
    localparam logic [N_OP-1:0] OP_BEQ  = N_OP'(15);
    localparam logic [N_OP-1:0] OP_BNE  = N_OP'(16);

    logic [1:0]          r_state;
    logic [N_BUS_IN-1:0] r_pc;
    logic [N_BUS-1:0]    r_acc;
    logic [N_BUS-1:0]    r_ir;

    logic [1:0]          w_state_next;
    logic [N_BUS_IN-1:0] w_pc_next;
    logic [N_BUS-1:0]    w_acc_next;
    logic [N_BUS-1:0]    w_ir_next;

    logic [N_BUS-1:0]    w_cur_instr;
    logic [N_OP-1:0]     w_opcode;
    logic [N_BUS_IN-1:0] w_operand;
    logic [N_BUS-1:0]    w_imm;
    logic [N_BUS-1:0]    w_operand_b;
    logic [N_BUS-1:0]    w_alu;
    logic [N_BUS_IN-1:0] w_pc_inc;
    logic                w_is_mem;
    logic                w_is_store;
    logic                w_active;
    logic                w_branch_taken;

    // While waiting, the held instruction in IR drives decode so the
    // request and address stay stable even if the fetched word changes.
    always_comb begin
        w_cur_instr = (r_state == ST_WAIT) ? r_ir : i_instr;
        w_opcode    = w_cur_instr[N_BUS-1 -: N_OP];
        w_operand   = w_cur_instr[N_BUS_IN-1:0];
        w_imm       = {{(N_BUS-N_BUS_IN){w_operand[N_BUS_IN-1]}}, w_operand};
        w_pc_inc    = r_pc + N_BUS_IN'(1);
    end

    always_comb begin
        w_is_mem = 1'b0;
        case (w_opcode)
            OP_STO, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w_is_mem = 1'b1;
            default: w_is_mem = 1'b0;
        endcase
        w_is_store = (w_opcode == OP_STO);
    end

    always_comb begin
        w_active  = !i_reset && (r_state != ST_HALT);
        o_WrRam   = w_active && w_is_mem && w_is_store;
        o_RdRam   = w_active && w_is_mem && !w_is_store;
        o_Addr    = w_operand;
        o_In_Data = r_acc;
        o_acc     = r_acc;
        o_PC      = r_pc;
        o_halt    = (r_state == ST_HALT);
    end

    // Register and immediate forms share one ALU; only the B operand differs.
    always_comb begin
        w_operand_b = w_is_mem ? i_Out_Data : w_imm;
        w_alu       = r_acc;
        case (w_opcode)
            OP_LD,  OP_LDI:  w_alu = w_operand_b;
            OP_ADD, OP_ADDI: w_alu = r_acc + w_operand_b;
            OP_SUB, OP_SUBI: w_alu = r_acc - w_operand_b;
            OP_AND, OP_ANDI: w_alu = r_acc & w_operand_b;
            OP_OR,  OP_ORI:  w_alu = r_acc | w_operand_b;
            OP_XOR, OP_XORI: w_alu = r_acc ^ w_operand_b;
            default:         w_alu = r_acc;
        endcase
    end

    // Branch conditions look at the accumulator as it stands this cycle.
    always_comb begin
        w_branch_taken = 1'b0;
        case (w_opcode)
            OP_JMP:  w_branch_taken = 1'b1;
            OP_BEQ:  w_branch_taken = (r_acc == '0);
            OP_BNE:  w_branch_taken = (r_acc != '0);
            default: w_branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_acc_next   = r_acc;
        w_ir_next    = r_ir;
        case (r_state)
            ST_RUN: begin
                if (w_opcode == OP_HLT) begin
                    w_state_next = ST_HALT;
                end else if (w_is_mem) begin
                    if (i_mem_ready) begin
                        w_acc_next = w_alu;
                        w_pc_next  = w_pc_inc;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_ir_next    = i_instr;
                    end
                end else begin
                    w_acc_next = w_alu;
                    w_pc_next  = w_branch_taken ? w_operand : w_pc_inc;
                end
            end
            ST_WAIT: begin
                if (i_mem_ready) begin
                    w_acc_next   = w_alu;
                    w_pc_next    = w_pc_inc;
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_acc   <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_acc   <= w_acc_next;
            r_ir    <= w_ir_next;
        end
    end

endmodule
